// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and helpers for the register-file write arbiter.
// Holds the default geometry, the register count and the register-0 (discard) address.
package rf_write_arbiter_pkg;

    localparam int NREQ_DEF  = 3;
    localparam int AW_DEF    = 3;
    localparam int DW_DEF    = 20;
    localparam int NREG_DEF  = 1 << AW_DEF;
    localparam int REG0_ADDR = 0;
    localparam logic [7:0] DROP_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == DROP_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Requester-side and register-file-side signals of the write arbiter.
// slave = arbiter view, master = requesters / register-file view.
interface rf_write_arbiter_if
    import rf_write_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               stall;
    logic               we3;
    logic [AW-1:0]      a3;
    logic [DW-1:0]      wd3;
    logic [1:0]         grant_id;
    logic [(1<<AW)-1:0] busy;
    logic [7:0]         drop_cnt;

    modport slave (
        input  req_valid, req_addr, req_data, stall,
        output req_ready, we3, a3, wd3, grant_id, busy, drop_cnt
    );

    modport master (
        output req_valid, req_addr, req_data, stall,
        input  req_ready, we3, a3, wd3, grant_id, busy, drop_cnt
    );
endinterface

// File: rtl/rf_write_arbiter_rr_grant.sv
// Combinational round-robin grant: first valid request at or after the pointer,
// wrapping modulo NREQ; returns a one-hot grant and its index.
module rr_grant #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [1:0]      i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [1:0]      o_idx
);
    logic       w_found;
    logic [1:0] w_cand;

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = 2'((int'(i_ptr) + k) % NREQ);
            if (!w_found && i_req[w_cand]) begin
                w_found          = 1'b1;
                o_grant[w_cand]  = 1'b1;
                o_idx            = w_cand;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a registered
// output stage, per-register pending-write tracking and a register-0 drop counter.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    rf_write_arbiter_if.slave  bus
);
    logic [1:0]         r_ptr;
    logic               r_we3;
    logic [AW-1:0]      r_a3;
    logic [DW-1:0]      r_wd3;
    logic [1:0]         r_gid;
    logic [7:0]         r_drop;

    logic [NREQ-1:0]    w_grant;
    logic [NREQ-1:0]    w_ready;
    logic [1:0]         w_idx;
    logic [1:0]         w_ptr_nxt;
    logic               w_xfer;
    logic [AW-1:0]      w_addr;
    logic [DW-1:0]      w_data;
    logic               w_is_reg0;
    logic [(1<<AW)-1:0] w_busy;

    rr_grant #(.NREQ(NREQ)) u_rr_grant (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    // Grants are suppressed while the port is stalled and while reset is held.
    assign w_ready   = (rst && !bus.stall) ? w_grant : '0;
    assign w_xfer    = |w_ready;
    assign w_addr    = bus.req_addr[int'(w_idx)*AW +: AW];
    assign w_data    = bus.req_data[int'(w_idx)*DW +: DW];
    assign w_is_reg0 = (w_addr == AW'(REG0_ADDR));
    assign w_ptr_nxt = (int'(w_idx) == NREQ-1) ? 2'd0 : w_idx + 2'd1;

    // A register is pending from its accepting edge until the commit edge:
    // the current transfer plus whatever sits in the output stage.
    always_comb begin
        w_busy = '0;
        if (r_we3)
            w_busy[r_a3] = 1'b1;
        if (w_xfer && !w_is_reg0)
            w_busy[w_addr] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr  <= '0;
            r_we3  <= 1'b0;
            r_a3   <= '0;
            r_wd3  <= '0;
            r_gid  <= '0;
            r_drop <= '0;
        end else if (w_xfer) begin
            r_ptr <= w_ptr_nxt;
            r_we3 <= !w_is_reg0;
            if (w_is_reg0) begin
                r_drop <= sat_inc(r_drop);
            end else begin
                r_a3  <= w_addr;
                r_wd3 <= w_data;
                r_gid <= w_idx;
            end
        end else begin
            r_we3 <= 1'b0;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.we3       = r_we3;
    assign bus.a3        = r_a3;
    assign bus.wd3       = r_wd3;
    assign bus.grant_id  = r_gid;
    assign bus.busy      = w_busy;
    assign bus.drop_cnt  = r_drop;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: a per-cycle vector table followed by
// hand-written sequences for rotation, drop saturation, same-address, stall and reset.
module tb_rf_write_arbiter;
    import rf_write_arbiter_pkg::*;

    localparam int NREQ = 3;
    localparam int AW   = 3;
    localparam int DW   = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    rf_write_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]        valid;
        logic [2:0][2:0]   addr;
        logic [2:0][19:0]  data;
        logic              stall;
        logic [2:0]        ready;
        logic              we3;
        logic [2:0]        a3;
        logic [19:0]       wd3;
        logic [1:0]        gid;
        logic [NREG_DEF-1:0] busy;
        logic [7:0]        drop;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic [2:0] valid, input logic [8:0] addr,
                                input logic [59:0] data, input logic stall,
                                input logic [2:0] ready, input logic we3, input logic [2:0] a3,
                                input logic [19:0] wd3, input logic [1:0] gid,
                                input logic [7:0] busy, input logic [7:0] drop);
        vec_t v;
        v.valid = valid; v.addr = addr; v.data = data; v.stall = stall;
        v.ready = ready; v.we3 = we3; v.a3 = a3; v.wd3 = wd3; v.gid = gid;
        v.busy = busy; v.drop = drop;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] valid, input logic [8:0] addr, input logic [59:0] data);
        bus.req_valid = valid;
        bus.req_addr  = addr;
        bus.req_data  = data;
    endtask

    // Holds reset across an edge with all requesters asking, checks the reset
    // state, then releases at the start of a cycle (cycle 0 for the caller).
    task automatic do_reset(input string tag);
        rst       = 1'b0;
        bus.stall = 1'b0;
        drive(3'b111, {3'd1, 3'd2, 3'd3}, {20'h3, 20'h2, 20'h1});
        tick();
        check({tag, " rst ready"}, bus.req_ready, 0);
        check({tag, " rst we3"},   bus.we3, 0);
        check({tag, " rst a3"},    bus.a3, 0);
        check({tag, " rst wd3"},   bus.wd3, 0);
        check({tag, " rst gid"},   bus.grant_id, 0);
        check({tag, " rst busy"},  bus.busy, 0);
        check({tag, " rst drop"},  bus.drop_cnt, 0);
        drive(3'b000, '0, '0);
        rst = 1'b1;
    endtask

    initial begin
        logic [2:0] exp_ready;
        logic       bad_seen;

        bus.stall = 1'b0;
        drive(3'b000, '0, '0);

        //            valid    addr {2,1,0}          data {2,1,0}                     stl ready  we3 a3   wd3         gid busy   drop
        vecs[0]  = mk(3'b010, {3'd0,3'd5,3'd0}, {20'h0, 20'hABCDE, 20'h0},        0, 3'b010, 0, 3'd0, 20'h0,     2'd0, 8'h20, 8'd0);
        vecs[1]  = mk(3'b000, '0,               '0,                               0, 3'b000, 1, 3'd5, 20'hABCDE, 2'd1, 8'h20, 8'd0);
        vecs[2]  = mk(3'b000, '0,               '0,                               0, 3'b000, 0, 3'd5, 20'hABCDE, 2'd1, 8'h00, 8'd0);
        vecs[3]  = mk(3'b111, {3'd4,3'd2,3'd1}, {20'h44, 20'h22, 20'h11},         0, 3'b100, 0, 3'd5, 20'hABCDE, 2'd1, 8'h10, 8'd0);
        vecs[4]  = mk(3'b111, {3'd4,3'd2,3'd1}, {20'h44, 20'h22, 20'h11},         0, 3'b001, 1, 3'd4, 20'h44,    2'd2, 8'h12, 8'd0);
        vecs[5]  = mk(3'b111, {3'd4,3'd2,3'd1}, {20'h44, 20'h22, 20'h11},         0, 3'b010, 1, 3'd1, 20'h11,    2'd0, 8'h06, 8'd0);
        vecs[6]  = mk(3'b011, {3'd4,3'd2,3'd1}, {20'h44, 20'h22, 20'h11},         1, 3'b000, 1, 3'd2, 20'h22,    2'd1, 8'h04, 8'd0);
        vecs[7]  = mk(3'b011, {3'd4,3'd2,3'd1}, {20'h44, 20'h22, 20'h11},         0, 3'b001, 0, 3'd2, 20'h22,    2'd1, 8'h02, 8'd0);
        vecs[8]  = mk(3'b011, {3'd4,3'd2,3'd1}, {20'h44, 20'h22, 20'h11},         0, 3'b010, 1, 3'd1, 20'h11,    2'd0, 8'h06, 8'd0);
        vecs[9]  = mk(3'b000, '0,               '0,                               0, 3'b000, 1, 3'd2, 20'h22,    2'd1, 8'h04, 8'd0);
        vecs[10] = mk(3'b001, {3'd0,3'd0,3'd0}, {20'h0, 20'h0, 20'h12345},        0, 3'b001, 0, 3'd2, 20'h22,    2'd1, 8'h00, 8'd0);
        vecs[11] = mk(3'b000, '0,               '0,                               0, 3'b000, 0, 3'd2, 20'h22,    2'd1, 8'h00, 8'd1);

        do_reset("table");
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].valid, vecs[i].addr, vecs[i].data);
            bus.stall = vecs[i].stall;
            #1;
            check($sformatf("v%0d ready", i), bus.req_ready, vecs[i].ready);
            check($sformatf("v%0d we3", i),   bus.we3,       vecs[i].we3);
            check($sformatf("v%0d a3", i),    bus.a3,        vecs[i].a3);
            check($sformatf("v%0d wd3", i),   bus.wd3,       vecs[i].wd3);
            check($sformatf("v%0d gid", i),   bus.grant_id,  vecs[i].gid);
            check($sformatf("v%0d busy", i),  bus.busy,      vecs[i].busy);
            check($sformatf("v%0d drop", i),  bus.drop_cnt,  vecs[i].drop);
            tick();
        end
        bus.stall = 1'b0;

        // All three continuously valid: strict 0,1,2 rotation, one write per cycle.
        do_reset("rot");
        drive(3'b111, {3'd3, 3'd2, 3'd1}, {20'h3, 20'h2, 20'h1});
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_ready = 3'b001 << (c % 3);
            check($sformatf("rot c%0d ready", c), bus.req_ready, exp_ready);
            if (c >= 1) begin
                check($sformatf("rot c%0d we3", c), bus.we3, 1);
                check($sformatf("rot c%0d gid", c), bus.grant_id, (c - 1) % 3);
                check($sformatf("rot c%0d a3", c),  bus.a3, ((c - 1) % 3) + 1);
            end
            tick();
        end
        drive(3'b000, '0, '0);

        // 300 register-0 writes: always accepted, never written, counter saturates.
        do_reset("drop");
        drive(3'b001, {3'd0, 3'd0, 3'd0}, {20'h0, 20'h0, 20'h12345});
        bad_seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (c == 0) begin
                check("drop c0 ready", bus.req_ready, 3'b001);
                check("drop c0 cnt", bus.drop_cnt, 0);
            end
            if (c == 1)
                check("drop c1 cnt", bus.drop_cnt, 1);
            if (bus.req_ready !== 3'b001 || bus.we3 !== 1'b0 || bus.busy !== '0)
                bad_seen = 1'b1;
            tick();
        end
        drive(3'b000, '0, '0);
        #1;
        check("drop sat cnt", bus.drop_cnt, 255);
        check("drop ready/we3/busy anomaly", bad_seen, 0);
        tick();

        // Same address from req 0 and req 2: serialized 1 then 2, busy[3] held 3 cycles.
        do_reset("same");
        drive(3'b101, {3'd3, 3'd0, 3'd3}, {20'h2, 20'h0, 20'h1});
        #1;
        check("same c0 ready", bus.req_ready, 3'b001);
        check("same c0 busy", bus.busy, 8'h08);
        tick();
        drive(3'b100, {3'd3, 3'd0, 3'd3}, {20'h2, 20'h0, 20'h1});
        #1;
        check("same c1 ready", bus.req_ready, 3'b100);
        check("same c1 we3", bus.we3, 1);
        check("same c1 a3", bus.a3, 3);
        check("same c1 wd3", bus.wd3, 1);
        check("same c1 busy", bus.busy, 8'h08);
        tick();
        drive(3'b000, '0, '0);
        #1;
        check("same c2 we3", bus.we3, 1);
        check("same c2 wd3", bus.wd3, 2);
        check("same c2 gid", bus.grant_id, 2);
        check("same c2 busy", bus.busy, 8'h08);
        tick();
        check("same c3 busy", bus.busy, 0);
        check("same c3 we3", bus.we3, 0);

        // Stall for four cycles holds off req 1; grant on the first unstalled cycle.
        do_reset("stall");
        bus.stall = 1'b1;
        drive(3'b010, {3'd0, 3'd6, 3'd0}, {20'h0, 20'h777, 20'h0});
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("stall c%0d ready", c), bus.req_ready, 0);
            check($sformatf("stall c%0d we3", c), bus.we3, 0);
            tick();
        end
        bus.stall = 1'b0;
        #1;
        check("stall release ready", bus.req_ready, 3'b010);
        tick();
        drive(3'b000, '0, '0);
        check("stall release we3", bus.we3, 1);
        check("stall release a3", bus.a3, 6);
        check("stall release gid", bus.grant_id, 1);

        // Reset mid-write: output stage dropped at once, pointer back to 0.
        do_reset("midrst");
        drive(3'b011, {3'd0, 3'd7, 3'd2}, {20'h0, 20'h6, 20'h5});
        #1;
        check("midrst c0 ready", bus.req_ready, 3'b001);
        tick();
        drive(3'b010, {3'd0, 3'd7, 3'd2}, {20'h0, 20'h6, 20'h5});
        check("midrst c1 we3", bus.we3, 1);
        rst = 1'b0;
        #1;
        check("midrst asserted we3", bus.we3, 0);
        check("midrst asserted busy", bus.busy, 0);
        check("midrst asserted ready", bus.req_ready, 0);
        drive(3'b011, {3'd0, 3'd7, 3'd2}, {20'h0, 20'h6, 20'h5});
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst release ready", bus.req_ready, 3'b001);
        tick();
        drive(3'b000, '0, '0);
        check("midrst release we3", bus.we3, 1);
        check("midrst release a3", bus.a3, 2);
        check("midrst release gid", bus.grant_id, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
